// File: rtl/ds_pkt_gen.sv
// Packet traffic source for the NAP tx data stream.
// Define DS_PKT_GEN_THROTTLE_EN for LFSR-driven beat throttling.
module ds_pkt_gen #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic [15:0]           i_num_pkts,
  input  logic [7:0]            i_pkt_len,
  input  logic [ADDR_WIDTH-1:0] i_dest,
  output logic                  o_valid,
  output logic                  o_sop,
  output logic                  o_eop,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [ADDR_WIDTH-1:0] o_addr,
  input  logic                  i_ready,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [31:0]           o_pkt_count
);

  localparam int LANES = DATA_WIDTH / 32;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } state_t;

  state_t                r_state;
  logic                  r_valid;
  logic                  r_sop;
  logic                  r_eop;
  logic [DATA_WIDTH-1:0] r_data;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_busy;
  logic                  r_done;
  logic [31:0]           r_pkt_count;
  logic [31:0]           r_beat_ctr;
  logic [7:0]            r_beat_idx;
  logic [7:0]            r_len;
  logic [15:0]           r_num_pkts;
  logic                  r_stop_pend;

  logic [7:0]            w_len_in;
  logic                  w_accept;
  logic [31:0]           w_ctr_n;
  logic [7:0]            w_idx_n;
  logic                  w_stop;
  logic                  w_last;
  logic                  w_go;

  function automatic logic [DATA_WIDTH-1:0] f_pat(
    input logic [31:0] base
  );
    logic [DATA_WIDTH-1:0] d;
    d = '0;
    for (int k = 0; k < LANES; k++) begin
      d[k*32 +: 32] = base + 32'(k);
    end
    return d;
  endfunction

  assign w_len_in = (i_pkt_len == 8'd0) ? 8'd1 : i_pkt_len;
  assign w_accept = r_valid & i_ready;
  assign w_ctr_n  = r_beat_ctr + 32'd1;
  assign w_idx_n  = r_eop ? 8'd0 : r_beat_idx + 8'd1;
  assign w_stop   = r_stop_pend | i_stop;
  assign w_last   = (r_num_pkts != 16'd0) &&
                    (r_pkt_count + 32'd1 == {16'd0, r_num_pkts});

`ifdef DS_PKT_GEN_THROTTLE_EN
  logic [15:0] r_lfsr;
  logic        w_fb;

  assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_go = ~r_lfsr[0];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_lfsr <= 16'hACE1;
    end else if (i_start && r_state != SEND) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_fb};
    end
  end
`else
  assign w_go = 1'b1;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_valid     <= 1'b0;
      r_sop       <= 1'b0;
      r_eop       <= 1'b0;
      r_data      <= '0;
      r_addr      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pkt_count <= 32'd0;
      r_beat_ctr  <= 32'd0;
      r_beat_idx  <= 8'd0;
      r_len       <= 8'd1;
      r_num_pkts  <= 16'd0;
      r_stop_pend <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE, DONE: begin
          if (i_start) begin
            r_state     <= SEND;
            r_num_pkts  <= i_num_pkts;
            r_len       <= w_len_in;
            r_addr      <= i_dest;
            r_pkt_count <= 32'd0;
            r_beat_idx  <= 8'd0;
            r_stop_pend <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b1;
            r_valid     <= w_go;
            r_sop       <= 1'b1;
            r_eop       <= (w_len_in == 8'd1);
            r_data      <= f_pat(r_beat_ctr);
          end
        end
        SEND: begin
          if (i_stop) r_stop_pend <= 1'b1;
          if (w_accept) begin
            r_beat_ctr <= w_ctr_n;
            if (r_eop) r_pkt_count <= r_pkt_count + 32'd1;
            if (r_eop && (w_last || w_stop)) begin
              r_state <= DONE;
              r_valid <= 1'b0;
              r_sop   <= 1'b0;
              r_eop   <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              // next beat is staged even while throttled
              r_valid    <= w_go;
              r_beat_idx <= w_idx_n;
              r_sop      <= (w_idx_n == 8'd0);
              r_eop      <= (w_idx_n == r_len - 8'd1);
              r_data     <= f_pat(w_ctr_n);
            end
          end else if (!r_valid) begin
            if (r_beat_idx == 8'd0 && w_stop) begin
              r_state <= DONE;
              r_sop   <= 1'b0;
              r_eop   <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else if (w_go) begin
              r_valid <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_valid     = r_valid;
  assign o_sop       = r_sop;
  assign o_eop       = r_eop;
  assign o_data      = r_data;
  assign o_addr      = r_addr;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_pkt_count = r_pkt_count;

endmodule

// File: tb/tb_ds_pkt_gen.sv
// Directed bench for ds_pkt_gen.
// Throttle scenario runs when DS_PKT_GEN_THROTTLE_EN is defined.
module tb_ds_pkt_gen;

  logic         i_clk;
  logic         i_reset;
  logic         i_start;
  logic         i_stop;
  logic [15:0]  i_num_pkts;
  logic [7:0]   i_pkt_len;
  logic [3:0]   i_dest;
  logic         o_valid;
  logic         o_sop;
  logic         o_eop;
  logic [255:0] o_data;
  logic [3:0]   o_addr;
  logic         i_ready;
  logic         o_busy;
  logic         o_done;
  logic [31:0]  o_pkt_count;

  int          n_pass;
  int          n_total;
  logic [31:0] ctr;
  logic [103:0] exp_v;
  logic [103:0] got_v;
  logic [34:0]  exp_e;
  logic [34:0]  got_e;

  ds_pkt_gen #(
    .DATA_WIDTH(256),
    .ADDR_WIDTH(4)
  ) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_start    (i_start),
    .i_stop     (i_stop),
    .i_num_pkts (i_num_pkts),
    .i_pkt_len  (i_pkt_len),
    .i_dest     (i_dest),
    .o_valid    (o_valid),
    .o_sop      (o_sop),
    .o_eop      (o_eop),
    .o_data     (o_data),
    .o_addr     (o_addr),
    .i_ready    (i_ready),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_pkt_count(o_pkt_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic start_run(input logic [15:0] n,
                           input logic [7:0] len,
                           input logic [3:0] d);
    i_num_pkts = n;
    i_pkt_len  = len;
    i_dest     = d;
    i_start    = 1'b1;
    tick();
    i_start    = 1'b0;
  endtask

  task automatic do_reset;
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    tick();
    ctr = 32'd0;
  endtask

  function automatic logic [103:0] beat_vec;
    return {o_valid, o_sop, o_eop, o_busy, o_data[31:0],
            o_data[63:32], o_addr, o_pkt_count};
  endfunction

  function automatic logic [34:0] end_vec;
    return {o_valid, o_busy, o_done, o_pkt_count};
  endfunction

  task automatic test_reset;
    i_reset = 1'b1;
    #1;
    n_total++;
    got_v = {o_valid, o_sop, o_eop, o_busy, o_done, o_data[98:0]};
    if (got_v !== 104'd0 || o_data !== '0 || o_addr !== 4'd0 ||
        o_pkt_count !== 32'd0) begin
      $display("FAIL reset: got v%b s%b e%b b%b d%b data%h addr%h cnt%0d want all 0",
               o_valid, o_sop, o_eop, o_busy, o_done, o_data, o_addr, o_pkt_count);
    end else n_pass++;
    tick();
    i_reset = 1'b0;
    tick();
    tick();
    n_total++;
    exp_e = 35'd0;
    got_e = end_vec();
    if (got_e !== exp_e) begin
      $display("FAIL idle_after_reset: got %h want %h", got_e, exp_e);
    end else n_pass++;
    ctr = 32'd0;
  endtask

  task automatic test_basic;
    start_run(16'd3, 8'd4, 4'h5);
    for (int b = 0; b < 12; b++) begin
      exp_v = {1'b1, (b % 4 == 0), (b % 4 == 3), 1'b1, ctr,
               ctr + 32'd1, 4'h5, 32'(b / 4)};
      got_v = beat_vec();
      n_total++;
      if (got_v !== exp_v) begin
        $display("FAIL basic beat %0d: got %h want %h", b, got_v, exp_v);
      end else n_pass++;
      ctr++;
      tick();
    end
    exp_e = {1'b0, 1'b0, 1'b1, 32'd3};
    got_e = end_vec();
    n_total++;
    if (got_e !== exp_e) begin
      $display("FAIL basic done: got %h want %h", got_e, exp_e);
    end else n_pass++;
  endtask

  task automatic test_len0;
    start_run(16'd2, 8'd0, 4'hA);
    for (int b = 0; b < 2; b++) begin
      exp_v = {1'b1, 1'b1, 1'b1, 1'b1, ctr, ctr + 32'd1,
               4'hA, 32'(b)};
      got_v = beat_vec();
      n_total++;
      if (got_v !== exp_v) begin
        $display("FAIL len0 beat %0d: got %h want %h", b, got_v, exp_v);
      end else n_pass++;
      ctr++;
      tick();
    end
    exp_e = {1'b0, 1'b0, 1'b1, 32'd2};
    got_e = end_vec();
    n_total++;
    if (got_e !== exp_e) begin
      $display("FAIL len0 done: got %h want %h", got_e, exp_e);
    end else n_pass++;
  endtask

  task automatic test_backpressure;
    start_run(16'd1, 8'd4, 4'h3);
    ctr++;
    tick();
    i_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_v = {1'b1, 1'b0, 1'b0, 1'b1, ctr, ctr + 32'd1,
               4'h3, 32'd0};
      got_v = beat_vec();
      n_total++;
      if (got_v !== exp_v) begin
        $display("FAIL bp hold %0d: got %h want %h", i, got_v, exp_v);
      end else n_pass++;
      tick();
    end
    i_ready = 1'b1;
    for (int b = 1; b < 4; b++) begin
      exp_v = {1'b1, 1'b0, (b == 3), 1'b1, ctr, ctr + 32'd1,
               4'h3, 32'd0};
      got_v = beat_vec();
      n_total++;
      if (got_v !== exp_v) begin
        $display("FAIL bp beat %0d: got %h want %h", b, got_v, exp_v);
      end else n_pass++;
      ctr++;
      tick();
    end
    exp_e = {1'b0, 1'b0, 1'b1, 32'd1};
    got_e = end_vec();
    n_total++;
    if (got_e !== exp_e) begin
      $display("FAIL bp done: got %h want %h", got_e, exp_e);
    end else n_pass++;
  endtask

  task automatic test_stop;
    start_run(16'd0, 8'd2, 4'h7);
    for (int b = 0; b < 12; b++) begin
      exp_v = {1'b1, (b % 2 == 0), (b % 2 == 1), 1'b1, ctr,
               ctr + 32'd1, 4'h7, 32'(b / 2)};
      got_v = beat_vec();
      n_total++;
      if (got_v !== exp_v) begin
        $display("FAIL stop beat %0d: got %h want %h", b, got_v, exp_v);
      end else n_pass++;
      if (b == 10) i_stop = 1'b1;
      if (b == 3) begin
        i_num_pkts = 16'd1;
        i_start    = 1'b1;
      end
      ctr++;
      tick();
      i_stop  = 1'b0;
      i_start = 1'b0;
    end
    i_stop = 1'b1;
    tick();
    tick();
    i_stop = 1'b0;
    exp_e = {1'b0, 1'b0, 1'b1, 32'd6};
    got_e = end_vec();
    n_total++;
    if (got_e !== exp_e) begin
      $display("FAIL stop done: got %h want %h", got_e, exp_e);
    end else n_pass++;
  endtask

  task automatic test_reset_mid;
    start_run(16'd1, 8'd4, 4'h2);
    tick();
    i_reset = 1'b1;
    #1;
    exp_e = 35'd0;
    got_e = end_vec();
    n_total++;
    if (got_e !== exp_e || o_sop !== 1'b0 || o_eop !== 1'b0) begin
      $display("FAIL reset_mid drop: got %h s%b e%b want 0", got_e, o_sop, o_eop);
    end else n_pass++;
    tick();
    i_reset = 1'b0;
    ctr = 32'd0;
    tick();
    start_run(16'd1, 8'd1, 4'h6);
    exp_v = {1'b1, 1'b1, 1'b1, 1'b1, 32'd0, 32'd1, 4'h6, 32'd0};
    got_v = beat_vec();
    n_total++;
    if (got_v !== exp_v) begin
      $display("FAIL reset_mid beat: got %h want %h", got_v, exp_v);
    end else n_pass++;
    ctr++;
    tick();
    exp_e = {1'b0, 1'b0, 1'b1, 32'd1};
    got_e = end_vec();
    n_total++;
    if (got_e !== exp_e) begin
      $display("FAIL reset_mid done: got %h want %h", got_e, exp_e);
    end else n_pass++;
  endtask

  task automatic test_start_stop;
    do_reset();
    i_stop = 1'b1;
    start_run(16'd2, 8'd1, 4'h1);
    i_stop = 1'b0;
    for (int b = 0; b < 2; b++) begin
      exp_v = {1'b1, 1'b1, 1'b1, 1'b1, ctr, ctr + 32'd1,
               4'h1, 32'(b)};
      got_v = beat_vec();
      n_total++;
      if (got_v !== exp_v) begin
        $display("FAIL start_stop beat %0d: got %h want %h", b, got_v, exp_v);
      end else n_pass++;
      ctr++;
      tick();
    end
    exp_e = {1'b0, 1'b0, 1'b1, 32'd2};
    got_e = end_vec();
    n_total++;
    if (got_e !== exp_e) begin
      $display("FAIL start_stop done: got %h want %h", got_e, exp_e);
    end else n_pass++;
  endtask

  task automatic test_throttle;
    int          cyc;
    int          beats;
    int          gaps;
    logic        pv;
    logic        pr;
    logic [31:0] pd;
    do_reset();
    start_run(16'd4, 8'd8, 4'h9);
    cyc   = 0;
    beats = 0;
    gaps  = 0;
    pv    = 1'b0;
    pr    = 1'b1;
    pd    = 32'd0;
    while (!o_done && cyc < 3000) begin
      i_ready = (cyc % 3) != 2;
      if (pv && !pr) begin
        n_total++;
        if (o_valid !== 1'b1 || o_data[31:0] !== pd) begin
          $display("FAIL thr hold cyc %0d: got v%b %h want v1 %h",
                   cyc, o_valid, o_data[31:0], pd);
        end else n_pass++;
      end
      if (!o_valid) gaps++;
      if (o_valid && i_ready) begin
        exp_v = {1'b1, (beats % 8 == 0), (beats % 8 == 7), 1'b1,
                 ctr, ctr + 32'd1, 4'h9, 32'(beats / 8)};
        got_v = beat_vec();
        n_total++;
        if (got_v !== exp_v) begin
          $display("FAIL thr beat %0d: got %h want %h", beats, got_v, exp_v);
        end else n_pass++;
        beats++;
        ctr++;
      end
      pv = o_valid;
      pr = i_ready;
      pd = o_data[31:0];
      tick();
      cyc++;
    end
    i_ready = 1'b1;
    exp_e = {1'b0, 1'b0, 1'b1, 32'd4};
    got_e = end_vec();
    n_total++;
    if (got_e !== exp_e || beats != 32) begin
      $display("FAIL thr done: got %h beats %0d want %h beats 32",
               got_e, beats, exp_e);
    end else n_pass++;
    n_total++;
    if (gaps == 0) begin
      $display("FAIL thr gaps: got %0d want >0", gaps);
    end else n_pass++;
  endtask

  initial begin
    n_pass     = 0;
    n_total    = 0;
    ctr        = 32'd0;
    i_reset    = 1'b0;
    i_start    = 1'b0;
    i_stop     = 1'b0;
    i_num_pkts = 16'd0;
    i_pkt_len  = 8'd0;
    i_dest     = 4'd0;
    i_ready    = 1'b1;
    #2;
    test_reset();
`ifdef DS_PKT_GEN_THROTTLE_EN
    test_throttle();
`else
    test_basic();
    test_len0();
    test_backpressure();
    test_stop();
    test_reset_mid();
    test_start_stop();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
